// File: rtl/asg_pattern_generator.sv
// -----------------------------------------------------------------------------
// asg_pattern_generator
//
// Multi-channel test-target generator for the azimuth signal path. After each
// accepted radar trigger a sweep of SIZE microsecond slots runs. Every channel
// is a small counter machine (start / period / width / count) that emits a
// periodic pulse train in slot time. No per-slot pattern memory is used.
//
// Each channel holds two configuration banks:
//   - pending: written by CFG_WE.
//   - active: loaded from pending on every accepted trigger.
// A write therefore never disturbs a sweep that is already running. After
// reset, channel 0 reproduces the legacy fixed test pattern:
// START=100, PERIOD=400, WIDTH=3, COUNT=8.
//
// Ports:
//   SYS_CLK        system clock
//   SYS_RST_N      asynchronous active-low reset (clears both config banks)
//   EN             global enable; low forces IDLE and all outputs low
//   RADAR_TRIG_PE  one-cycle trigger; starts or restarts a sweep at slot 0
//   USEC_PE        one-cycle microsecond tick; advances the slot while running
//   CFG_WE         write strobe into the pending bank of channel CFG_CH
//   CFG_CH         channel index; out-of-range indices are ignored
//   CFG_START      first pulse slot
//   CFG_PERIOD     pulse spacing in slots
//   CFG_WIDTH      pulse width in slots
//   CFG_COUNT      number of pulses; 0 disables the channel
//   CH_SIGNAL      registered per-channel pulse outputs
//   GEN_SIGNAL     registered OR of all channel outputs, same latency
//   ACTIVE         high while a sweep is running
//   CFG_ERR        sticky per-channel flag for an invalid configuration
//                  (set or cleared at copy time)
// -----------------------------------------------------------------------------
module asg_pattern_generator #(
  parameter int SIZE     = 3200,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 12,
  parameter int NUM_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST_N,
  input  logic                EN,
  input  logic                RADAR_TRIG_PE,
  input  logic                USEC_PE,
  input  logic                CFG_WE,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [CNT_W-1:0]    CFG_START,
  input  logic [CNT_W-1:0]    CFG_PERIOD,
  input  logic [CNT_W-1:0]    CFG_WIDTH,
  input  logic [NUM_W-1:0]    CFG_COUNT,
  output logic [CHANNELS-1:0] CH_SIGNAL,
  output logic                GEN_SIGNAL,
  output logic                ACTIVE,
  output logic [CHANNELS-1:0] CFG_ERR
);

  typedef enum logic {
    G_IDLE = 1'b0,
    G_RUN  = 1'b1
  } g_state_t;

  typedef enum logic [1:0] {
    CH_WAIT = 2'd0,
    CH_HIGH = 2'd1,
    CH_LOW  = 2'd2,
    CH_DONE = 2'd3
  } ch_state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SIZE - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [NUM_W-1:0] NUM_ZERO   = {NUM_W{1'b0}};
  localparam logic [NUM_W-1:0] NUM_ONE    = NUM_W'(1'b1);
  localparam logic [CNT_W-1:0] RST_START  = CNT_W'(32'd100);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(32'd400);
  localparam logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(32'd3);
  localparam logic [NUM_W-1:0] RST_COUNT  = NUM_W'(32'd8);

  // A channel is usable when it has pulses, a non-zero width, a LOW gap
  // between pulses (single-pulse trains do not need one) and a start slot
  // inside the sweep.
  function automatic logic cfg_valid(input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] period,
                                     input logic [CNT_W-1:0] width,
                                     input logic [NUM_W-1:0] count);
    return (count != NUM_ZERO) && (width != CNT_ZERO) &&
           ((count == NUM_ONE) || (width < period)) &&
           (start <= SLOT_LAST);
  endfunction

  // Configuration banks
  logic [CNT_W-1:0] pend_start_r  [CHANNELS];
  logic [CNT_W-1:0] pend_period_r [CHANNELS];
  logic [CNT_W-1:0] pend_width_r  [CHANNELS];
  logic [NUM_W-1:0] pend_count_r  [CHANNELS];
  logic [CNT_W-1:0] act_start_r   [CHANNELS];
  logic [CNT_W-1:0] act_period_r  [CHANNELS];
  logic [CNT_W-1:0] act_width_r   [CHANNELS];
  logic [NUM_W-1:0] act_count_r   [CHANNELS];

  // Global sweep state
  g_state_t         g_state_r;
  g_state_t         g_state_s;
  logic [CNT_W-1:0] slot_r;
  logic [CNT_W-1:0] slot_s;

  // Channel machines:
  //   cnt: slots spent in the current HIGH or LOW phase.
  //   idx: 1-based number of the current pulse.
  ch_state_t        ch_state_r [CHANNELS];
  ch_state_t        ch_state_s [CHANNELS];
  logic [CNT_W-1:0] cnt_r      [CHANNELS];
  logic [CNT_W-1:0] cnt_s      [CHANNELS];
  logic [NUM_W-1:0] idx_r      [CHANNELS];
  logic [NUM_W-1:0] idx_s      [CHANNELS];

  logic [CHANNELS-1:0] pend_valid_s;
  logic [CHANNELS-1:0] ch_signal_r;
  logic [CHANNELS-1:0] ch_signal_s;
  logic                gen_signal_r;
  logic [CHANNELS-1:0] cfg_err_r;
  logic [CHANNELS-1:0] cfg_err_s;

  logic trig_acc_s;
  logic adv_s;

  // Trigger is honoured only while enabled. A plain tick advances channels
  // only when it moves to another slot of the running sweep; the tick on the
  // last slot ends the sweep instead. A trigger in the same cycle wins and
  // the tick is dropped.
  assign trig_acc_s = RADAR_TRIG_PE & EN;
  assign adv_s      = EN & ~RADAR_TRIG_PE & USEC_PE &
                      (g_state_r == G_RUN) & (slot_r != SLOT_LAST);

  // Pending-bank writes and the pending-to-active copy on an accepted trigger
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      for (int c = 0; c < CHANNELS; c++) begin
        pend_start_r[c]  <= (c == 0) ? RST_START  : CNT_ZERO;
        pend_period_r[c] <= (c == 0) ? RST_PERIOD : CNT_ZERO;
        pend_width_r[c]  <= (c == 0) ? RST_WIDTH  : CNT_ZERO;
        pend_count_r[c]  <= (c == 0) ? RST_COUNT  : NUM_ZERO;
        act_start_r[c]   <= (c == 0) ? RST_START  : CNT_ZERO;
        act_period_r[c]  <= (c == 0) ? RST_PERIOD : CNT_ZERO;
        act_width_r[c]   <= (c == 0) ? RST_WIDTH  : CNT_ZERO;
        act_count_r[c]   <= (c == 0) ? RST_COUNT  : NUM_ZERO;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // The copy takes the pending value from before any same-cycle write.
        if (trig_acc_s) begin
          act_start_r[c]  <= pend_start_r[c];
          act_period_r[c] <= pend_period_r[c];
          act_width_r[c]  <= pend_width_r[c];
          act_count_r[c]  <= pend_count_r[c];
        end
        if (CFG_WE && (CFG_CH == CH_W'(c))) begin
          pend_start_r[c]  <= CFG_START;
          pend_period_r[c] <= CFG_PERIOD;
          pend_width_r[c]  <= CFG_WIDTH;
          pend_count_r[c]  <= CFG_COUNT;
        end
      end
    end
  end

  // Validity of each pending configuration, evaluated at copy time
  always_comb begin
    pend_valid_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      pend_valid_s[c] = cfg_valid(pend_start_r[c], pend_period_r[c],
                                  pend_width_r[c], pend_count_r[c]);
    end
  end

  // Global sweep FSM: next state and next slot
  always_comb begin
    g_state_s = g_state_r;
    slot_s    = slot_r;
    if (!EN) begin
      g_state_s = G_IDLE;
    end else if (RADAR_TRIG_PE) begin
      g_state_s = G_RUN;
      slot_s    = CNT_ZERO;
    end else if ((g_state_r == G_RUN) && USEC_PE) begin
      if (slot_r == SLOT_LAST) begin
        g_state_s = G_IDLE;
      end else begin
        slot_s = slot_r + CNT_ONE;
      end
    end else begin
      g_state_s = g_state_r;
    end
  end

  // Channel FSMs, sticky error flags and next-slot channel outputs
  always_comb begin
    ch_signal_s = {CHANNELS{1'b0}};
    cfg_err_s   = cfg_err_r;
    for (int c = 0; c < CHANNELS; c++) begin
      ch_state_s[c] = ch_state_r[c];
      cnt_s[c]      = cnt_r[c];
      idx_s[c]      = idx_r[c];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (trig_acc_s) begin
        // Slot-0 entry uses the configuration being copied right now.
        if (!pend_valid_s[c]) begin
          ch_state_s[c] = CH_DONE;
          cnt_s[c]      = CNT_ZERO;
          idx_s[c]      = NUM_ZERO;
        end else if (pend_start_r[c] == CNT_ZERO) begin
          ch_state_s[c] = CH_HIGH;
          cnt_s[c]      = CNT_ONE;
          idx_s[c]      = NUM_ONE;
        end else begin
          ch_state_s[c] = CH_WAIT;
          cnt_s[c]      = CNT_ZERO;
          idx_s[c]      = NUM_ZERO;
        end
        if (pend_valid_s[c]) begin
          cfg_err_s[c] = 1'b0;
        end else if (pend_count_r[c] != NUM_ZERO) begin
          cfg_err_s[c] = 1'b1;
        end else begin
          cfg_err_s[c] = cfg_err_r[c];
        end
      end else if (adv_s) begin
        case (ch_state_r[c])
          CH_WAIT: begin
            if (slot_s == act_start_r[c]) begin
              ch_state_s[c] = CH_HIGH;
              cnt_s[c]      = CNT_ONE;
              idx_s[c]      = NUM_ONE;
            end else begin
              ch_state_s[c] = CH_WAIT;
            end
          end
          CH_HIGH: begin
            if (cnt_r[c] == act_width_r[c]) begin
              // Last pulse skips LOW so no gap rule is needed for COUNT=1.
              if (idx_r[c] == act_count_r[c]) begin
                ch_state_s[c] = CH_DONE;
              end else begin
                ch_state_s[c] = CH_LOW;
                cnt_s[c]      = CNT_ONE;
              end
            end else begin
              cnt_s[c] = cnt_r[c] + CNT_ONE;
            end
          end
          CH_LOW: begin
            if (cnt_r[c] == (act_period_r[c] - act_width_r[c])) begin
              ch_state_s[c] = CH_HIGH;
              cnt_s[c]      = CNT_ONE;
              idx_s[c]      = idx_r[c] + NUM_ONE;
            end else begin
              cnt_s[c] = cnt_r[c] + CNT_ONE;
            end
          end
          CH_DONE: begin
            ch_state_s[c] = CH_DONE;
          end
          default: begin
            ch_state_s[c] = CH_DONE;
          end
        endcase
      end else begin
        ch_state_s[c] = ch_state_r[c];
      end
      // Ending the sweep (last tick or EN low) truncates any running pulse.
      ch_signal_s[c] = (g_state_s == G_RUN) && (ch_state_s[c] == CH_HIGH);
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      g_state_r    <= G_IDLE;
      slot_r       <= CNT_ZERO;
      ch_signal_r  <= {CHANNELS{1'b0}};
      gen_signal_r <= 1'b0;
      cfg_err_r    <= {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        ch_state_r[c] <= CH_DONE;
        cnt_r[c]      <= CNT_ZERO;
        idx_r[c]      <= NUM_ZERO;
      end
    end else begin
      g_state_r    <= g_state_s;
      slot_r       <= slot_s;
      ch_signal_r  <= ch_signal_s;
      gen_signal_r <= |ch_signal_s;
      cfg_err_r    <= cfg_err_s;
      for (int c = 0; c < CHANNELS; c++) begin
        ch_state_r[c] <= ch_state_s[c];
        cnt_r[c]      <= cnt_s[c];
        idx_r[c]      <= idx_s[c];
      end
    end
  end

  assign CH_SIGNAL  = ch_signal_r;
  assign GEN_SIGNAL = gen_signal_r;
  assign ACTIVE     = (g_state_r == G_RUN);
  assign CFG_ERR    = cfg_err_r;

endmodule

// File: doc/asg_pattern_generator.md
# asg_pattern_generator

Programmable multi-channel test-target generator for the azimuth signal path. It emits periodic pulse trains, timed in microsecond slots after each radar trigger, without a SIZE-bit pattern vector: each channel is a small start/period/width/count counter machine. The block replaces fixed-pattern test generators and drives the same downstream input as the azimuth signal generator output. At reset it reproduces the legacy fixed test pattern on channel 0.

## Interface
Parameters:
- SIZE, 3200: sweep length in microsecond slots. Slots 0..SIZE-1.
- CHANNELS, 4: number of independent pulse channels, 1..16.
- CNT_W, 12: width of slot, start, period and width fields. Must satisfy 2^CNT_W > SIZE.
- NUM_W, 8: width of the pulse-count field.

Ports:
- SYS_CLK  in  1  system clock, 100 MHz.
- SYS_RST_N  in  1  asynchronous active-low reset.
- EN  in  1  global enable. Low forces IDLE and all outputs low.
- RADAR_TRIG_PE  in  1  one-cycle radar trigger pulse. Starts or restarts a sweep.
- USEC_PE  in  1  one-cycle microsecond tick. Advances the slot.
- CFG_WE  in  1  write strobe for one channel's pending configuration.
- CFG_CH  in  clog2(CHANNELS)  channel index. Writes to an out-of-range index are ignored.
- CFG_START, CFG_PERIOD, CFG_WIDTH  in  CNT_W each  first pulse slot, pulse spacing, pulse width.
- CFG_COUNT  in  NUM_W  number of pulses. 0 disables the channel.
- CH_SIGNAL  out  CHANNELS  per-channel registered pulse outputs.
- GEN_SIGNAL  out  1  registered OR of CH_SIGNAL.
- ACTIVE  out  1  high while a sweep is running.
- CFG_ERR  out  CHANNELS  sticky per channel. Set when the active config is invalid.

## Operation
- Configuration has two banks per channel: pending and active.
  - CFG_WE writes the pending bank.
  - The pending bank is copied to the active bank on every accepted trigger, so writes never change a running sweep.
- Reset values of both banks:
  - Channel 0: START=100, PERIOD=400, WIDTH=3, COUNT=8.
  - All other channels: COUNT=0.
- Validity: a channel is valid if COUNT≠0, WIDTH≠0, WIDTH<PERIOD and START<SIZE. COUNT=1 ignores the PERIOD rule.
  - An invalid channel with COUNT≠0 sets its CFG_ERR bit at copy time and stays low for the whole sweep.
  - CFG_ERR clears only on reset or on a later copy with a valid config.
- Global FSM states: IDLE, RUN.
  - IDLE → RUN: RADAR_TRIG_PE & EN. The slot counter is set to 0.
  - RUN → RUN: RADAR_TRIG_PE restarts the sweep. Slot goes to 0, channels reload, config is copied.
  - RUN → IDLE: USEC_PE while slot=SIZE-1, or EN low.
- Channel FSM states: WAIT, HIGH, LOW, DONE. A channel enters WAIT on trigger. Each transition consumes one USEC_PE, except the slot-0 entry.
  - WAIT → HIGH when slot reaches START.
  - HIGH lasts WIDTH slots, then LOW for PERIOD-WIDTH slots.
  - After the last of COUNT pulses, HIGH → DONE instead of LOW.
- Required output function: CH_SIGNAL[c] is high during slot s iff s=START+k·PERIOD+j, with 0≤k<COUNT, 0≤j<WIDTH, and s<SIZE.
- Pulses that extend past SIZE-1 are truncated at sweep end. There is no wrap into the next sweep.
- Outputs are low in IDLE and in WAIT/LOW/DONE.

## Timing
- All outputs are registered. Reset values: CH_SIGNAL=0, GEN_SIGNAL=0, ACTIVE=0, CFG_ERR=0, FSMs in IDLE.
- Latency from a trigger or tick to the new slot's output:
  - Slot 0 begins at the trigger cycle.
  - Outputs for a new slot appear on the SYS_CLK edge after the trigger or USEC_PE cycle (1-cycle latency).
  - With START=0, CH_SIGNAL rises 1 cycle after the trigger.
- GEN_SIGNAL has the same latency as CH_SIGNAL. It is not delayed an extra cycle.
- Simultaneous trigger and USEC_PE: the trigger wins, slot=0, and the tick is discarded.
- CFG_WE in the same cycle as the trigger: the new value is written to pending and is NOT copied. The copy uses the pre-write pending value.
- Trigger while EN=0 is ignored. No config copy occurs.
- EN falling mid-sweep: outputs go low on the next edge.
- SYS_RST_N asserted mid-sweep: asynchronous clear to the reset values, including the pending/active banks.
- USEC_PE ticks in IDLE are ignored.

## Test plan
- Reset defaults, EN=1, trigger, 3200 ticks → GEN_SIGNAL high exactly in slots 100-102, 500-502, ..., 2900-2902 (8 pulses, 24 slots total). ACTIVE falls after tick 3200.
- Channel 1 config START=0, PERIOD=5, WIDTH=2, COUNT=3, then trigger → CH_SIGNAL[1] high in slots 0,1,5,6,10,11. Rise 1 cycle after the trigger. GEN_SIGNAL is the OR with channel 0.
- Channel 2 config WIDTH=5, PERIOD=5, COUNT=2, then trigger → CFG_ERR[2]=1 and CH_SIGNAL[2] stays 0. Rewrite with WIDTH=4, then trigger → CFG_ERR[2] clears.
- Retrigger at slot 101 (mid-pulse), and separately trigger+USEC_PE in the same cycle → slot restarts at 0, the pulse drops within 1 cycle, and the next pulse is at slot 100 of the new sweep.
- CFG_WE at slot 600 (channel 0 START=50) → the current sweep is unchanged. The next sweep pulses at 50, 450, .... A START=3199, WIDTH=3 config → a single high slot 3199, truncated.
- SYS_RST_N low at slot 501 → all outputs 0 immediately. After release, ticks without a trigger produce no output.
